cache_ctrl: RTL and testbench
=============================

Name: cache_ctrl

Overview:
- Main sequencer for the 4-way, 128-set, 512-bit-line data array.
- Accepts one CPU word request at a time and looks up hit/victim information from the tag array.
- Drives data-array block and word writes, and runs write-back and refill transactions on a line-wide memory port.
- Blocking: at most one request is in flight.

Parameters:
- NUM_SETS, 128, sets per way; index width 7.
- ADDR_W, 32, byte address width; tag = addr[31:13], index = addr[12:6], word = addr[5:2].
- CNT_W, 16, width of the hit and miss statistics counters.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on clk, state cleared when 0.
- cpu_req_valid  input  1  request valid.
- cpu_req_ready  output  1  controller can accept a request.
- cpu_req_we  input  1  1 = word write, 0 = word read.
- cpu_req_addr  input  32  byte address.
- cpu_req_wdata  input  32  write data.
- cpu_resp_valid  output  1  one-cycle completion pulse.
- cpu_resp_rdata  output  32  read data; 0 for writes.
- tag_hit_way  input  4  one-hot hit for arr_index and the latched tag; combinational from the tag array.
- victim_way  input  2  replacement way for arr_index.
- victim_dirty  input  1  victim line dirty.
- victim_tag  input  19  victim line tag.
- tag_fill_we  output  1  write tag/valid=1/dirty=0 into tag_fill_way.
- tag_fill_way  output  2  fill way.
- tag_fill_tag  output  19  fill tag.
- tag_dirty_we  output  1  set dirty bit of arr_hit_way.
- arr_index  output  7  data/tag array index.
- arr_word_offset  output  4  word offset.
- arr_block_we  output  1  data array block write.
- arr_word_we  output  1  data array word write.
- arr_write_way  output  2  block write way.
- arr_hit_way  output  4  word write way, one-hot.
- arr_block_data  output  512  block write data.
- arr_word_data  output  32  word write data.
- data_out_0..data_out_3  input  512 each  data array read ports for arr_index.
- mem_req  output  1  memory request; held until mem_ack.
- mem_we  output  1  1 = write-back, 0 = refill read.
- mem_addr  output  32  line-aligned address; bits [5:0] = 0.
- mem_wdata  output  512  write-back line.
- mem_ack  input  1  memory completes the request in this cycle.
- mem_rdata  input  512  refill line; valid with mem_ack on a read.
- stat_hits  output  16  hit counter.
- stat_misses  output  16  miss counter.

Behaviour:
- States: IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND.
- Reset (reset==0 at edge):
  - state = IDLE, replay flag = 0.
  - Counters, latched request and cpu_resp_rdata = 0.
  - All enables, mem_req and cpu_resp_valid = 0.
  - Reset mid-transaction abandons the transaction: mem_req drops the next cycle and no response is issued.
- IDLE:
  - cpu_req_ready = 1.
  - On valid&ready, latch addr/we/wdata and go to LOOKUP.
  - mem_ack is ignored.
- Index and offset: arr_index and arr_word_offset come from the latched address in all non-IDLE states, and from cpu_req_addr in IDLE.
- LOOKUP (1 cycle) on hit (tag_hit_way != 0):
  - If several bits are set, the lowest-numbered way wins and arr_hit_way is its one-hot.
  - Read: register the selected way's word [off*32 +: 32] into cpu_resp_rdata.
  - Write: assert arr_word_we, arr_hit_way, arr_word_data = wdata and tag_dirty_we combinationally this cycle.
  - stat_hits += 1 unless the replay flag is set.
  - Next state: RESPOND.
- LOOKUP on miss:
  - Latch victim_way, victim_tag, and the selected data_out_x into the write-back buffer.
  - stat_misses += 1.
  - Next state: WRITEBACK if victim_dirty, else REFILL.
- WRITEBACK:
  - mem_req = 1, mem_we = 1, mem_addr = {victim_tag, index, 6'b0}, mem_wdata = buffer.
  - On mem_ack go to REFILL; mem_ack in the first cycle is legal.
- REFILL:
  - mem_req = 1, mem_we = 0, mem_addr = {tag, index, 6'b0}.
  - On mem_ack, in that cycle: arr_block_we = 1, arr_write_way = latched victim, arr_block_data = mem_rdata, tag_fill_we = 1, tag_fill_way = victim, tag_fill_tag = tag.
  - Then set the replay flag and go to LOOKUP; the replay hits.
- RESPOND: cpu_resp_valid = 1 for one cycle, clear the replay flag, go to IDLE.
- Latency, request accepted at T:
  - Hit: response at T+2.
  - Clean miss: T+3 + refill ack wait.
  - Dirty miss: adds the write-back ack wait.
- Counters saturate at 16'hFFFF.
- Request stability: mem_addr, mem_we and mem_wdata stay stable while mem_req is high.
- Enable exclusivity: arr_block_we and arr_word_we are never both 1.

Test Plan:
- Reset low for 2 cycles, then high -> all outputs 0, cpu_req_ready = 1.
- Read 0x0000_1044 after refill of its line with mem_rdata word1 = 0xDEADBEEF:
  - Expected: mem_req with mem_addr 0x0000_1040, mem_we 0, then arr_block_we, then resp_valid with rdata 0xDEADBEEF.
  - Expected: stat_misses 1, stat_hits 0.
- Repeat the same read:
  - Expected: resp_valid exactly 2 cycles after acceptance, no mem_req, stat_hits 1.
- Write 0xCAFEF00D to 0x0000_1048 (hit, way 2):
  - Expected: single arr_word_we with arr_hit_way 4'b0100, offset 2, plus tag_dirty_we.
- Miss with victim_dirty = 1, victim_tag 0x00003, index 0x41:
  - Expected: write-back at mem_addr 0x0000_7040 carrying the victim's data_out.
  - Expected: after ack, refill; mem_req stays stable through a 5-cycle ack delay.
- Reset low during REFILL:
  - Expected: next cycle mem_req 0, state IDLE, no cpu_resp_valid.
  - Expected: counters 0 and a later request served normally.

Source files
------------

// File: rtl/cache_ctrl_if.sv
// rtl/cache_ctrl_if.sv - CPU, tag/data array and memory port bundle for cache_ctrl
interface cache_ctrl_if #(
  parameter int NUM_SETS = 128,
  parameter int ADDR_W   = 32,
  parameter int CNT_W    = 16
);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_W - IDX_W - 6;

  logic              cpu_req_valid;
  logic              cpu_req_ready;
  logic              cpu_req_we;
  logic [ADDR_W-1:0] cpu_req_addr;
  logic [31:0]       cpu_req_wdata;
  logic              cpu_resp_valid;
  logic [31:0]       cpu_resp_rdata;

  logic [3:0]        tag_hit_way;
  logic [1:0]        victim_way;
  logic              victim_dirty;
  logic [TAG_W-1:0]  victim_tag;
  logic              tag_fill_we;
  logic [1:0]        tag_fill_way;
  logic [TAG_W-1:0]  tag_fill_tag;
  logic              tag_dirty_we;

  logic [IDX_W-1:0]  arr_index;
  logic [3:0]        arr_word_offset;
  logic              arr_block_we;
  logic              arr_word_we;
  logic [1:0]        arr_write_way;
  logic [3:0]        arr_hit_way;
  logic [511:0]      arr_block_data;
  logic [31:0]       arr_word_data;
  logic [511:0]      data_out_0;
  logic [511:0]      data_out_1;
  logic [511:0]      data_out_2;
  logic [511:0]      data_out_3;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [511:0]      mem_wdata;
  logic              mem_ack;
  logic [511:0]      mem_rdata;

  logic [CNT_W-1:0]  stat_hits;
  logic [CNT_W-1:0]  stat_misses;

  modport master (
    input  cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata,
    output cpu_req_ready, cpu_resp_valid, cpu_resp_rdata,
    input  tag_hit_way, victim_way, victim_dirty, victim_tag,
    output tag_fill_we, tag_fill_way, tag_fill_tag, tag_dirty_we,
    output arr_index, arr_word_offset, arr_block_we, arr_word_we,
    output arr_write_way, arr_hit_way, arr_block_data, arr_word_data,
    input  data_out_0, data_out_1, data_out_2, data_out_3,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata,
    output stat_hits, stat_misses
  );

  modport slave (
    output cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata,
    input  cpu_req_ready, cpu_resp_valid, cpu_resp_rdata,
    output tag_hit_way, victim_way, victim_dirty, victim_tag,
    input  tag_fill_we, tag_fill_way, tag_fill_tag, tag_dirty_we,
    input  arr_index, arr_word_offset, arr_block_we, arr_word_we,
    input  arr_write_way, arr_hit_way, arr_block_data, arr_word_data,
    output data_out_0, data_out_1, data_out_2, data_out_3,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata,
    input  stat_hits, stat_misses
  );
endinterface

// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - blocking 4-way cache sequencer: lookup, write-back, refill, replay
module cache_ctrl #(
  parameter int NUM_SETS = 128,
  parameter int ADDR_W   = 32,
  parameter int CNT_W    = 16
) (
  input  logic         clk,
  input  logic         reset,
  cache_ctrl_if.master bus
);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_W - IDX_W - 6;

  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} state_t;

  state_t            state;
  logic              replay;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [1:0]        vic_way;
  logic [TAG_W-1:0]  vic_tag;
  logic [511:0]      wb_buf;
  logic [CNT_W-1:0]  hits;
  logic [CNT_W-1:0]  misses;
  logic [31:0]       resp_rdata;
  logic              resp_valid;

  logic [ADDR_W-1:0] cur_addr;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [3:0]        req_off;
  logic              hit_any;
  logic [3:0]        hit_oh;
  logic [1:0]        hit_idx;
  logic [1:0]        sel_way;
  logic [511:0]      sel_line;
  logic              lookup;
  logic              refill_done;

  assign cur_addr    = (state == IDLE) ? bus.cpu_req_addr : req_addr;
  assign req_tag     = req_addr[ADDR_W-1 -: TAG_W];
  assign req_idx     = req_addr[6 +: IDX_W];
  assign req_off     = req_addr[5:2];
  assign hit_any     = |bus.tag_hit_way;
  // Isolate the lowest set bit so a multi-way hit resolves to the lowest way.
  assign hit_oh      = bus.tag_hit_way & (~bus.tag_hit_way + 4'd1);
  assign sel_way     = hit_any ? hit_idx : bus.victim_way;
  assign lookup      = (state == LOOKUP);
  assign refill_done = (state == REFILL) && bus.mem_ack;

  always_comb begin
    hit_idx = 2'd0;
    if (hit_oh[1]) hit_idx = 2'd1;
    if (hit_oh[2]) hit_idx = 2'd2;
    if (hit_oh[3]) hit_idx = 2'd3;
  end

  always_comb begin
    sel_line = bus.data_out_0;
    case (sel_way)
      2'd1:    sel_line = bus.data_out_1;
      2'd2:    sel_line = bus.data_out_2;
      2'd3:    sel_line = bus.data_out_3;
      default: sel_line = bus.data_out_0;
    endcase
  end

  assign bus.cpu_req_ready   = (state == IDLE);
  assign bus.cpu_resp_valid  = resp_valid;
  assign bus.cpu_resp_rdata  = resp_rdata;
  assign bus.arr_index       = cur_addr[6 +: IDX_W];
  assign bus.arr_word_offset = cur_addr[5:2];
  assign bus.arr_word_we     = lookup && hit_any && req_we;
  assign bus.tag_dirty_we    = lookup && hit_any && req_we;
  assign bus.arr_hit_way     = lookup ? hit_oh : 4'd0;
  assign bus.arr_word_data   = (lookup && hit_any && req_we) ? req_wdata : 32'd0;
  assign bus.arr_block_we    = refill_done;
  assign bus.arr_write_way   = vic_way;
  assign bus.arr_block_data  = refill_done ? bus.mem_rdata : 512'd0;
  assign bus.tag_fill_we     = refill_done;
  assign bus.tag_fill_way    = vic_way;
  assign bus.tag_fill_tag    = req_tag;
  assign bus.mem_req         = (state == WRITEBACK) || (state == REFILL);
  assign bus.mem_we          = (state == WRITEBACK);
  assign bus.mem_wdata       = (state == WRITEBACK) ? wb_buf : 512'd0;
  assign bus.stat_hits       = hits;
  assign bus.stat_misses     = misses;

  always_comb begin
    bus.mem_addr = '0;
    if (state == WRITEBACK) bus.mem_addr = {vic_tag, req_idx, 6'b0};
    else if (state == REFILL) bus.mem_addr = {req_tag, req_idx, 6'b0};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      replay     <= 1'b0;
      req_we     <= 1'b0;
      req_addr   <= '0;
      req_wdata  <= '0;
      vic_way    <= '0;
      vic_tag    <= '0;
      wb_buf     <= '0;
      hits       <= '0;
      misses     <= '0;
      resp_rdata <= '0;
      resp_valid <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cpu_req_valid) begin
            req_we    <= bus.cpu_req_we;
            req_addr  <= bus.cpu_req_addr;
            req_wdata <= bus.cpu_req_wdata;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit_any) begin
            resp_rdata <= req_we ? 32'd0 : sel_line[{req_off, 5'd0} +: 32];
            if (!replay && hits != '1) hits <= hits + 1'b1;
            resp_valid <= 1'b1;
            state      <= RESPOND;
          end else begin
            vic_way <= bus.victim_way;
            vic_tag <= bus.victim_tag;
            wb_buf  <= sel_line;
            if (misses != '1) misses <= misses + 1'b1;
            state   <= bus.victim_dirty ? WRITEBACK : REFILL;
          end
        end
        WRITEBACK: begin
          if (bus.mem_ack) state <= REFILL;
        end
        REFILL: begin
          if (bus.mem_ack) begin
            replay <= 1'b1;
            state  <= LOOKUP;
          end
        end
        RESPOND: begin
          replay <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_ctrl.sv
// tb/tb_cache_ctrl.sv - bench for cache_ctrl with tag/data array and memory models
module tb_cache_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  cache_ctrl_if bus();
  cache_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [511:0] mem_line(input logic [31:0] la);
    logic [511:0] l;
    for (int o = 0; o < 16; o++) l[o*32 +: 32] = mem_word(la + 32'(o * 4));
    return l;
  endfunction

  function automatic logic [511:0] env_line(input int w, input int i);
    logic [511:0] l;
    for (int o = 0; o < 16; o++) l[o*32 +: 32] = {4'hE, 2'(w), 7'(i), 4'(o), 15'h0};
    return l;
  endfunction

  // Environment: tag/data array owned by the bench, with optional forced lookups.
  logic [18:0]  env_tag   [4][128];
  logic         env_valid [4][128];
  logic         env_dirty [4][128];
  logic [511:0] env_data  [4][128];
  logic [1:0]   env_ptr   [128];
  logic         env_clear;
  logic [31:0]  cur_addr;
  logic         ovr_hit_en, ovr_vic_en, ovr_vic_dirty;
  logic [3:0]   ovr_hit;
  logic [1:0]   ovr_vic_way;
  logic [18:0]  ovr_vic_tag;
  int           mem_delay;
  logic [1:0]   pv;

  always_comb begin
    bus.tag_hit_way = 4'd0;
    for (int w = 0; w < 4; w++)
      if (env_valid[w][bus.arr_index] && env_tag[w][bus.arr_index] == cur_addr[31:13])
        bus.tag_hit_way[w] = 1'b1;
    if (ovr_hit_en) bus.tag_hit_way = ovr_hit;
    pv               = env_ptr[bus.arr_index];
    bus.victim_way   = pv;
    bus.victim_dirty = env_dirty[pv][bus.arr_index];
    bus.victim_tag   = env_tag[pv][bus.arr_index];
    if (ovr_vic_en) begin
      bus.victim_way   = ovr_vic_way;
      bus.victim_dirty = ovr_vic_dirty;
      bus.victim_tag   = ovr_vic_tag;
    end
    bus.data_out_0 = env_data[0][bus.arr_index];
    bus.data_out_1 = env_data[1][bus.arr_index];
    bus.data_out_2 = env_data[2][bus.arr_index];
    bus.data_out_3 = env_data[3][bus.arr_index];
  end

  always @(posedge clk) begin
    if (env_clear) begin
      for (int w = 0; w < 4; w++)
        for (int i = 0; i < 128; i++) begin
          env_valid[w][i] <= 1'b0;
          env_dirty[w][i] <= 1'b0;
          env_tag[w][i]   <= '0;
          env_data[w][i]  <= env_line(w, i);
        end
      for (int i = 0; i < 128; i++) env_ptr[i] <= 2'd0;
    end else begin
      if (bus.tag_fill_we) begin
        env_tag[bus.tag_fill_way][bus.arr_index]   <= bus.tag_fill_tag;
        env_valid[bus.tag_fill_way][bus.arr_index] <= 1'b1;
        env_dirty[bus.tag_fill_way][bus.arr_index] <= 1'b0;
        env_ptr[bus.arr_index]                     <= bus.tag_fill_way + 2'd1;
      end
      if (bus.arr_block_we) env_data[bus.arr_write_way][bus.arr_index] <= bus.arr_block_data;
      for (int w = 0; w < 4; w++) begin
        if (bus.arr_word_we && bus.arr_hit_way[w])
          env_data[w][bus.arr_index][{bus.arr_word_offset, 5'd0} +: 32] <= bus.arr_word_data;
        if (bus.tag_dirty_we && bus.arr_hit_way[w]) env_dirty[w][bus.arr_index] <= 1'b1;
      end
    end
  end

  // Memory: backing store, fixed ack delay per request, request-stability check.
  logic [511:0] bk_mem [logic [31:0]];
  logic [31:0]  rq_addr_q [$];
  logic         rq_we_q   [$];
  logic [511:0] rq_wd_q   [$];
  int           stab_err = 0;

  initial begin
    int wl;
    logic [31:0]  sa;
    logic         sw;
    logic [511:0] sd, tmp;
    tmp = mem_line(32'h1040);
    tmp[63:32] = 32'hDEAD_BEEF;
    bk_mem[32'h1040] = tmp;
    wl = -1;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (reset && bus.mem_req) begin
        if (wl < 0) begin
          wl = mem_delay;
          sa = bus.mem_addr; sw = bus.mem_we; sd = bus.mem_wdata;
          rq_addr_q.push_back(sa); rq_we_q.push_back(sw); rq_wd_q.push_back(sd);
        end else if (bus.mem_addr !== sa || bus.mem_we !== sw || bus.mem_wdata !== sd) begin
          stab_err++;
        end
        if (wl == 0) begin
          bus.mem_ack = 1'b1;
          if (sw) bk_mem[sa] = sd;
          else bus.mem_rdata = bk_mem.exists(sa) ? bk_mem[sa] : mem_line(sa);
          wl = -1;
        end else begin
          wl--;
        end
      end else begin
        wl = -1;
      end
    end
  end

  int         n_word = 0, n_dirty = 0, n_blk = 0, n_excl = 0, n_resp = 0;
  logic [3:0] last_hway;
  logic [3:0] last_off;
  logic [31:0] last_wdata;

  always @(negedge clk) begin
    #1;
    if (reset) begin
      if (bus.arr_word_we) begin
        n_word++;
        last_hway = bus.arr_hit_way; last_off = bus.arr_word_offset; last_wdata = bus.arr_word_data;
      end
      if (bus.tag_dirty_we) n_dirty++;
      if (bus.arr_block_we) n_blk++;
      if (bus.arr_block_we && bus.arr_word_we) n_excl++;
      if (bus.cpu_resp_valid) n_resp++;
    end
  end

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd);
    int n;
    @(negedge clk);
    cur_addr = addr;
    bus.cpu_req_valid = 1'b1; bus.cpu_req_we = we;
    bus.cpu_req_addr = addr; bus.cpu_req_wdata = wd;
    n = 0;
    while (!bus.cpu_req_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.cpu_req_valid = 1'b0;
    lat = 1;
    while (!bus.cpu_resp_valid && lat < 400) begin @(negedge clk); lat++; end
    rd = bus.cpu_resp_rdata;
    @(negedge clk);
    chk("resp_pulse_len", bus.cpu_resp_valid, 1'b0);
    chk("ready_after_resp", bus.cpu_req_ready, 1'b1);
  endtask

  typedef struct {
    logic we; logic [31:0] addr; logic [31:0] wdata;
    logic hit_en; logic [3:0] hit;
    logic vic_en; logic [1:0] vic_way; logic vic_dirty; logic [18:0] vic_tag;
    int delay; int lat; logic [31:0] rdata;
    int nreq; logic [31:0] addr0; logic we0;
    int nword; logic [3:0] hway; logic [3:0] woff;
    int hits; int misses;
  } vec_t;

  vec_t vt [5];
  logic [19:0] rset [2][$];
  logic [31:0] ref_mem [logic [31:0]];

  initial begin
    int lat, s_req, s_word, s_dirty, s_blk, s_resp, n, m_hits, m_misses;
    logic [31:0] rd;
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int lat, s_req, s_word, s_dirty, s_blk, s_resp, n, m_hits, m_misses;
    logic [31:0] rd;
    vt[0] = '{0, 32'h1044, 0, 0, 4'h0, 0, 2'd0, 0, 19'h0, 0, 4, 32'hDEAD_BEEF, 1, 32'h1040, 0, 0, 4'h0, 4'h0, 0, 1};
    vt[1] = '{0, 32'h1044, 0, 0, 4'h0, 0, 2'd0, 0, 19'h0, 0, 2, 32'hDEAD_BEEF, 0, 32'h0, 0, 0, 4'h0, 4'h0, 1, 1};
    vt[2] = '{1, 32'h1048, 32'hCAFE_F00D, 1, 4'b0100, 0, 2'd0, 0, 19'h0, 0, 2, 32'h0, 0, 32'h0, 0, 1, 4'b0100, 4'h2, 2, 1};
    vt[3] = '{0, 32'h1048, 0, 1, 4'b1010, 0, 2'd0, 0, 19'h0, 0, 2, 32'hE609_0000, 0, 32'h0, 0, 0, 4'h0, 4'h0, 3, 1};
    vt[4] = '{0, 32'hB044, 0, 0, 4'h0, 1, 2'd1, 1, 19'h3, 5, 15, mem_word(32'hB044), 2, 32'h7040, 1, 0, 4'h0, 4'h0, 3, 2};

    reset = 1'b0; env_clear = 1'b1; cur_addr = '0; mem_delay = 0;
    ovr_hit_en = 0; ovr_hit = '0; ovr_vic_en = 0; ovr_vic_way = '0; ovr_vic_dirty = 0; ovr_vic_tag = '0;
    bus.cpu_req_valid = 0; bus.cpu_req_we = 0; bus.cpu_req_addr = '0; bus.cpu_req_wdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1; env_clear = 1'b0;
    @(negedge clk);
    chk("rst_ready", bus.cpu_req_ready, 1'b1);
    chk("rst_resp_valid", bus.cpu_resp_valid, 1'b0);
    chk("rst_resp_rdata", bus.cpu_resp_rdata, 32'h0);
    chk("rst_mem_req", {bus.mem_req, bus.mem_we, bus.mem_addr}, 34'h0);
    chk("rst_enables", {bus.arr_block_we, bus.arr_word_we, bus.tag_fill_we, bus.tag_dirty_we}, 4'h0);
    chk("rst_counters", {bus.stat_hits, bus.stat_misses}, 32'h0);

    for (int i = 0; i < 5; i++) begin
      ovr_hit_en = vt[i].hit_en; ovr_hit = vt[i].hit;
      ovr_vic_en = vt[i].vic_en; ovr_vic_way = vt[i].vic_way;
      ovr_vic_dirty = vt[i].vic_dirty; ovr_vic_tag = vt[i].vic_tag;
      mem_delay = vt[i].delay;
      s_req = rq_addr_q.size(); s_word = n_word; s_dirty = n_dirty; s_blk = n_blk;
      do_req(vt[i].we, vt[i].addr, vt[i].wdata, lat, rd);
      chk($sformatf("v%0d_latency", i), lat, vt[i].lat);
      chk($sformatf("v%0d_rdata", i), rd, vt[i].rdata);
      chk($sformatf("v%0d_mem_reqs", i), rq_addr_q.size() - s_req, vt[i].nreq);
      chk($sformatf("v%0d_block_we", i), n_blk - s_blk, (vt[i].nreq > 0) ? 1 : 0);
      chk($sformatf("v%0d_word_we", i), n_word - s_word, vt[i].nword);
      chk($sformatf("v%0d_dirty_we", i), n_dirty - s_dirty, vt[i].nword);
      if (vt[i].nreq > 0) begin
        chk($sformatf("v%0d_mem_addr", i), rq_addr_q[s_req], vt[i].addr0);
        chk($sformatf("v%0d_mem_we", i), rq_we_q[s_req], vt[i].we0);
        if (vt[i].we0) begin
          chk($sformatf("v%0d_wb_data", i), rq_wd_q[s_req], env_line(vt[i].vic_way, 32'h41));
          chk($sformatf("v%0d_refill_addr", i), rq_addr_q[s_req+1], {vt[i].addr[31:6], 6'b0});
        end
      end
      if (vt[i].nword > 0) begin
        chk($sformatf("v%0d_hit_way", i), last_hway, vt[i].hway);
        chk($sformatf("v%0d_word_off", i), last_off, vt[i].woff);
        chk($sformatf("v%0d_word_data", i), last_wdata, vt[i].wdata);
      end
      chk($sformatf("v%0d_hits", i), bus.stat_hits, vt[i].hits);
      chk($sformatf("v%0d_misses", i), bus.stat_misses, vt[i].misses);
    end
    ovr_hit_en = 0;

    // Reset while a refill is outstanding must abandon it silently.
    ovr_vic_en = 1; ovr_vic_way = 2'd3; ovr_vic_dirty = 0; ovr_vic_tag = '0;
    mem_delay = 30;
    @(negedge clk);
    cur_addr = 32'h0001_2044;
    bus.cpu_req_valid = 1; bus.cpu_req_we = 0; bus.cpu_req_addr = cur_addr;
    @(negedge clk);
    bus.cpu_req_valid = 0;
    n = 0;
    while (!(bus.mem_req && !bus.mem_we) && n < 20) begin @(negedge clk); n++; end
    chk("rr_refill_started", bus.mem_req && !bus.mem_we, 1'b1);
    s_resp = n_resp;
    reset = 1'b0;
    @(negedge clk);
    chk("rr_mem_req_drop", bus.mem_req, 1'b0);
    chk("rr_idle_ready", bus.cpu_req_ready, 1'b1);
    chk("rr_counters", {bus.stat_hits, bus.stat_misses}, 32'h0);
    reset = 1'b1; ovr_vic_en = 0; mem_delay = 0;
    repeat (5) @(negedge clk);
    chk("rr_no_resp", n_resp - s_resp, 0);
    do_req(0, 32'h1044, 0, lat, rd);
    chk("rr_after_lat", lat, 2);
    chk("rr_after_rdata", rd, 32'hDEAD_BEEF);
    chk("rr_after_hits", bus.stat_hits, 16'd1);

    // Randomized traffic on two sets against a FIFO-residency reference.
    @(negedge clk);
    reset = 1'b0; env_clear = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1; env_clear = 1'b0;
    m_hits = 0; m_misses = 0;
    for (int k = 0; k < 80; k++) begin
      logic we;
      logic [6:0] idx;
      logic [18:0] tag;
      logic [31:0] addr, wd, exp_rd, wa;
      int s, d, pos, exp_lat;
      logic ev_dirty;
      idx = ($urandom_range(0, 1) == 0) ? 7'h05 : 7'h2A;
      s = (idx == 7'h05) ? 0 : 1;
      tag = 19'($urandom_range(0, 6));
      addr = {tag, idx, 4'($urandom_range(0, 15)), 2'b00};
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      d = $urandom_range(0, 3);
      pos = -1;
      for (int q = 0; q < rset[s].size(); q++) if (rset[s][q][18:0] == tag) pos = q;
      if (pos >= 0) begin
        m_hits++;
        exp_lat = 2;
        if (we) rset[s][pos] = {1'b1, tag};
      end else begin
        m_misses++;
        ev_dirty = 1'b0;
        if (rset[s].size() == 4) ev_dirty = rset[s].pop_front()[19];
        rset[s].push_back({we, tag});
        exp_lat = 3 + (d + 1) + (ev_dirty ? d + 1 : 0);
      end
      wa = addr;
      exp_rd = we ? 32'h0 : (ref_mem.exists(wa) ? ref_mem[wa] : mem_word(wa));
      if (we) ref_mem[wa] = wd;
      mem_delay = d;
      do_req(we, addr, wd, lat, rd);
      chk($sformatf("rnd%0d_latency", k), lat, exp_lat);
      chk($sformatf("rnd%0d_rdata", k), rd, exp_rd);
    end
    chk("rnd_hits", bus.stat_hits, m_hits);
    chk("rnd_misses", bus.stat_misses, m_misses);
    chk("enable_exclusive", n_excl, 0);
    chk("mem_req_stable", stab_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
